pcie_tx_st_feeder: RTL

- Sits directly upstream of the Arria 10 PCIe hard IP TX Avalon-ST port (tx_st_*, 64-bit, single-packet-per-beat).
- Accepts TLP beats from the Wishbone-to-PCIe TX packetizer over a zero-latency valid/ready handshake and buffers them in a small FIFO.
- Re-emits the beats to the hard IP while honouring its fixed ready latency.
- Also provides a sticky framing-error flag and a transmitted-packet counter for debug.

---
 rtl/pcie_tx_st_feeder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pcie_tx_st_feeder.sv
// Beat buffer between the Wishbone TX packetizer and the Arria 10 PCIe HIP TX Avalon-ST port.
// Honours the HIP ready latency, flags sink framing errors and counts emitted TLPs.
module pcie_tx_st_feeder #(
  parameter int READY_LATENCY = 3,
  parameter int FIFO_DEPTH    = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 pld_clk,
  input  logic                 npor,
  input  logic                 snk_valid_i,
  output logic                 snk_ready_o,
  input  logic [63:0]          snk_data_i,
  input  logic                 snk_sop_i,
  input  logic                 snk_eop_i,
  input  logic                 snk_err_i,
  output logic                 tx_st_valid,
  input  logic                 tx_st_ready,
  output logic [63:0]          tx_st_data,
  output logic                 tx_st_sop,
  output logic                 tx_st_eop,
  output logic                 tx_st_err,
  output logic                 proto_err_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt_o
);

  // state  | meaning
  // IDLE   | between TLPs, next accepted beat must carry sop
  // IN_PKT | inside a multi-beat TLP, waiting for eop
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] DEPTH_V = OW'(FIFO_DEPTH);

  logic [66:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic [OW-1:0] occ_next;
  logic [66:0]   rd_word;
  logic          wr_en;
  logic          rd_en;
  logic          ready_ok;
  frame_state_t  frame_state;

  // ready_ok: HIP was ready READY_LATENCY cycles before the cycle being loaded
  if (READY_LATENCY == 1) begin : g_rl1
    assign ready_ok = tx_st_ready;
  end else begin : g_rlh
    logic [READY_LATENCY-1:1] rdy_h;
    always_ff @(posedge pld_clk or negedge npor) begin
      if (!npor) begin
        rdy_h <= '0;
      end else begin
        rdy_h[1] <= tx_st_ready;
        for (int i = 2; i < READY_LATENCY; i++) begin
          rdy_h[i] <= rdy_h[i-1];
        end
      end
    end
    assign ready_ok = rdy_h[READY_LATENCY-1];
  end

  assign wr_en   = snk_valid_i & snk_ready_o;
  assign rd_en   = ready_ok & (occ != '0);
  assign rd_word = mem[rd_ptr];

  always_comb begin
    occ_next = occ;
    if (wr_en && !rd_en) begin
      occ_next = occ + 1'b1;
    end else if (!wr_en && rd_en) begin
      occ_next = occ - 1'b1;
    end
  end

  always_ff @(posedge pld_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {snk_err_i, snk_eop_i, snk_sop_i, snk_data_i};
    end
  end

  always_ff @(posedge pld_clk or negedge npor) begin
    if (!npor) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      snk_ready_o <= 1'b0;
      tx_st_valid <= 1'b0;
      tx_st_data  <= '0;
      tx_st_sop   <= 1'b0;
      tx_st_eop   <= 1'b0;
      tx_st_err   <= 1'b0;
      pkt_cnt_o   <= '0;
    end else begin
      occ         <= occ_next;
      snk_ready_o <= (occ_next < DEPTH_V);
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr      <= rd_ptr + 1'b1;
        tx_st_valid <= 1'b1;
        tx_st_data  <= rd_word[63:0];
        tx_st_sop   <= rd_word[64];
        tx_st_eop   <= rd_word[65];
        tx_st_err   <= rd_word[66];
        if (rd_word[65]) begin
          pkt_cnt_o <= pkt_cnt_o + 1'b1;
        end
      end else begin
        // idle beat: qualifiers low, data keeps its last value
        tx_st_valid <= 1'b0;
        tx_st_sop   <= 1'b0;
        tx_st_eop   <= 1'b0;
        tx_st_err   <= 1'b0;
      end
    end
  end

  // offending beats are only flagged; they are still buffered and forwarded as-is
  always_ff @(posedge pld_clk or negedge npor) begin
    if (!npor) begin
      frame_state <= IDLE;
      proto_err_o <= 1'b0;
    end else if (wr_en) begin
      unique case (frame_state)
        IDLE: begin
          if (!snk_sop_i) begin
            proto_err_o <= 1'b1;
          end else if (!snk_eop_i) begin
            frame_state <= IN_PKT;
          end
        end
        IN_PKT: begin
          if (snk_sop_i) begin
            proto_err_o <= 1'b1;
          end else if (snk_eop_i) begin
            frame_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
